// File: rtl/tt_check_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
// Holds the FSM state encoding and the table-width function.
package tt_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of truth-table rows for an n-input device
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_lut.sv
// Expected-value lookup: selects one table bit by input index.
// Purely combinational; the caller registers the index.
module tt_lut
  import tt_check_pkg::*;
#(
  parameter int N_IN = 4,
  localparam int TT_W = tt_width(N_IN)
) (
  input  logic [TT_W-1:0] tt,
  input  logic [N_IN-1:0] idx,
  output logic            bit_o
);

  assign bit_o = tt[idx];

endmodule

// File: rtl/tt_sweep_checker.sv
// Walks a combinational device through every input vector and
// compares its settled output against a programmable truth table.
module tt_sweep_checker
  import tt_check_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int SETTLE = 2,
  localparam int TT_W = tt_width(N_IN),
  parameter logic [TT_W-1:0] RESET_TT = 16'h5DA9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [TT_W-1:0] cfg_tt,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            first_err_valid,
  output logic [N_IN-1:0] first_err_idx
);

  // Settle counter only needs to hold 0..SETTLE-1
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  if (SETTLE < 1) begin : g_bad_settle
    $error("tt_sweep_checker: SETTLE must be >= 1");
  end
  if (N_IN < 1 || N_IN > 8) begin : g_bad_nin
    $error("tt_sweep_checker: N_IN must be 1..8");
  end

  state_e          state_q, state_d;
  logic [TT_W-1:0] tbl_q, tbl_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fev_q, fev_d;
  logic [N_IN-1:0] fei_q, fei_d;
  logic            pass_q, pass_d;
  logic            exp_bit;
  logic            mis;
  logic            sample;

  tt_lut #(
    .N_IN (N_IN)
  ) u_lut (
    .tt    (tbl_q),
    .idx   (vec_q),
    .bit_o (exp_bit)
  );

  assign mis    = dut_in ^ exp_bit;
  assign sample = (cnt_q == CNT_LAST);

  // Next-state: table load, sweep sequencing and error accumulation
  always_comb begin
    state_d = state_q;
    tbl_d   = tbl_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fei_d   = fei_q;
    pass_d  = pass_q;

    if (cfg_we && state_q != RUN) begin
      tbl_d = cfg_tt;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d = IDLE;
          vec_d   = '0;
          pass_d  = 1'b0;
        end else if (start) begin
          state_d = RUN;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          fei_d   = '0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          vec_d   = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end else if (sample) begin
          cnt_d = '0;
          if (mis) begin
            err_d = err_q + 1'b1;
            if (!fev_q) begin
              fev_d = 1'b1;
              fei_d = vec_q;
            end
          end
          if (vec_q == '1) begin
            state_d = DONE;
            pass_d  = (err_d == '0);
            vec_d   = '0;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tbl_q   <= RESET_TT;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fei_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tbl_q   <= tbl_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fei_q   <= fei_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_out         = vec_q;
  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign pass            = pass_q;
  assign err_cnt         = err_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench for tt_sweep_checker: two configurations,
// directed device behaviours, results checked on each done rise.
module tb_tt_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [8:0] err;
    logic       pass;
    logic       fev;
    logic [7:0] fei;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [15:0] gold = 16'h5DA9;

  // Configuration 0: defaults
  logic        rst0, cfg_we0, start0, abort0, dut_in0;
  logic [15:0] cfg_tt0;
  logic [3:0]  vec0, fei0;
  logic        busy0, done0, pass0, fev0;
  logic [4:0]  err0;
  int          mode0;

  // Configuration 1: 2 inputs, SETTLE 1
  logic        rst1, cfg_we1, start1, abort1, dut_in1;
  logic [3:0]  cfg_tt1;
  logic [1:0]  vec1, fei1;
  logic        busy1, done1, pass1, fev1;
  logic [2:0]  err1;
  int          mode1;

  tt_sweep_checker #(
    .N_IN(4), .SETTLE(2), .RESET_TT(16'h5DA9)
  ) u0 (
    .clk(clk), .rst(rst0), .cfg_we(cfg_we0), .cfg_tt(cfg_tt0),
    .start(start0), .abort(abort0), .vec_out(vec0),
    .dut_in(dut_in0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .first_err_valid(fev0), .first_err_idx(fei0)
  );

  tt_sweep_checker #(
    .N_IN(2), .SETTLE(1), .RESET_TT(4'h6)
  ) u1 (
    .clk(clk), .rst(rst1), .cfg_we(cfg_we1), .cfg_tt(cfg_tt1),
    .start(start1), .abort(abort1), .vec_out(vec1),
    .dut_in(dut_in1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_err_valid(fev1), .first_err_idx(fei1)
  );

  // Behavioural devices under check
  always_comb begin
    dut_in0 = 1'b0;
    case (mode0)
      0: dut_in0 = gold[vec0];
      1: dut_in0 = 1'b0;
      2: dut_in0 = ~gold[vec0];
      3: dut_in0 = 1'b1;
      default: dut_in0 = 1'b0;
    endcase
  end

  always_comb begin
    dut_in1 = ^vec1;
    if (mode1 == 1) dut_in1 = ~(^vec1);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop expectation on each rising done
  logic done0_d = 1'b0;
  logic done1_d = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst0 && done0 && !done0_d) begin
      if (q0.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL u0 unexpected done: no expectation queued");
      end else begin
        e = q0.pop_front();
        chk("u0 err_cnt", 32'(err0), 32'(e.err));
        chk("u0 pass", 32'(pass0), 32'(e.pass));
        chk("u0 first_err_valid", 32'(fev0), 32'(e.fev));
        chk("u0 first_err_idx", 32'(fei0), 32'(e.fei));
      end
    end
    done0_d = rst0 ? 1'b0 : done0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst1 && done1 && !done1_d) begin
      if (q1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL u1 unexpected done: no expectation queued");
      end else begin
        e = q1.pop_front();
        chk("u1 err_cnt", 32'(err1), 32'(e.err));
        chk("u1 pass", 32'(pass1), 32'(e.pass));
        chk("u1 first_err_valid", 32'(fev1), 32'(e.fev));
        chk("u1 first_err_idx", 32'(fei1), 32'(e.fei));
      end
    end
    done1_d = rst1 ? 1'b0 : done1;
  end

  task automatic sweep0(input int mode, input exp_t e,
                        input logic load, input logic [15:0] tt,
                        input logic mid_cfg);
    int cyc;
    mode0 = mode;
    q0.push_back(e);
    cfg_we0 = load;
    cfg_tt0 = tt;
    start0  = 1'b1;
    tick();
    start0  = 1'b0;
    cfg_we0 = 1'b0;
    chk("u0 busy after start", 32'(busy0), 1);
    chk("u0 vec after start", 32'(vec0), 0);
    cyc = 0;
    while (!done0 && cyc < 200) begin
      cfg_we0 = mid_cfg && (cyc == 5);
      cfg_tt0 = 16'h0000;
      tick();
      cyc++;
    end
    cfg_we0 = 1'b0;
    chk("u0 sweep cycles", 32'(cyc), 32);
    chk("u0 busy at done", 32'(busy0), 0);
    tick();
    tick();
    chk("u0 done held", 32'(done0), 1);
  endtask

  task automatic chk_reset0();
    chk("u0 rst vec", 32'(vec0), 0);
    chk("u0 rst busy", 32'(busy0), 0);
    chk("u0 rst done", 32'(done0), 0);
    chk("u0 rst pass", 32'(pass0), 0);
    chk("u0 rst err", 32'(err0), 0);
    chk("u0 rst fev", 32'(fev0), 0);
    chk("u0 rst fei", 32'(fei0), 0);
  endtask

  task automatic chk_reset1();
    chk("u1 rst vec", 32'(vec1), 0);
    chk("u1 rst busy", 32'(busy1), 0);
    chk("u1 rst done", 32'(done1), 0);
    chk("u1 rst pass", 32'(pass1), 0);
    chk("u1 rst err", 32'(err1), 0);
    chk("u1 rst fev", 32'(fev1), 0);
    chk("u1 rst fei", 32'(fei1), 0);
  endtask

  initial begin
    int cyc;
    rst0 = 1'b1; cfg_we0 = 1'b0; cfg_tt0 = '0;
    start0 = 1'b0; abort0 = 1'b0; mode0 = 0;
    rst1 = 1'b1; cfg_we1 = 1'b0; cfg_tt1 = '0;
    start1 = 1'b0; abort1 = 1'b0; mode1 = 0;
    tick();
    tick();
    rst0 = 1'b0;
    rst1 = 1'b0;
    chk_reset0();
    chk_reset1();

    // Matching device, stuck-0, inverting, stuck-1
    sweep0(0, '{err: 9'd0,  pass: 1'b1, fev: 1'b0, fei: 8'd0},
           1'b0, 16'h0, 1'b0);
    sweep0(1, '{err: 9'd9,  pass: 1'b0, fev: 1'b1, fei: 8'd0},
           1'b0, 16'h0, 1'b0);
    sweep0(2, '{err: 9'd16, pass: 1'b0, fev: 1'b1, fei: 8'd0},
           1'b0, 16'h0, 1'b0);
    sweep0(3, '{err: 9'd7,  pass: 1'b0, fev: 1'b1, fei: 8'd1},
           1'b0, 16'h0, 1'b0);

    // Abort sampled at edge 10; samples 0..3 seen with stuck-0
    mode0  = 1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("u0 done cleared by start", 32'(done0), 0);
    for (int i = 1; i < 10; i++) tick();
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    chk("u0 abort busy", 32'(busy0), 0);
    chk("u0 abort done", 32'(done0), 0);
    chk("u0 abort vec", 32'(vec0), 0);
    chk("u0 abort pass", 32'(pass0), 0);
    tick();
    chk("u0 abort err held", 32'(err0), 2);
    chk("u0 abort fev held", 32'(fev0), 1);
    chk("u0 abort fei held", 32'(fei0), 0);

    // Restart after abort
    sweep0(0, '{err: 9'd0, pass: 1'b1, fev: 1'b0, fei: 8'd0},
           1'b0, 16'h0, 1'b0);
    // Table write during RUN must be ignored
    sweep0(1, '{err: 9'd9, pass: 1'b0, fev: 1'b1, fei: 8'd0},
           1'b0, 16'h0, 1'b1);
    // Table write with start in DONE is used by that sweep
    sweep0(1, '{err: 9'd0, pass: 1'b1, fev: 1'b0, fei: 8'd0},
           1'b1, 16'h0000, 1'b0);

    // Second configuration: XOR device, 4-cycle sweep
    mode1 = 0;
    q1.push_back('{err: 9'd0, pass: 1'b1, fev: 1'b0, fei: 8'd0});
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("u1 busy after start", 32'(busy1), 1);
    cyc = 0;
    while (!done1 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("u1 sweep cycles", 32'(cyc), 4);
    tick();

    // Inverted device, reset mid-sweep
    mode1  = 1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    chk("u1 mid busy", 32'(busy1), 1);
    chk("u1 mid err", 32'(err1), 2);
    chk("u1 mid vec", 32'(vec1), 2);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    chk_reset1();
    tick();

    chk("u0 scoreboard drained", 32'(q0.size()), 0);
    chk("u1 scoreboard drained", 32'(q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
